// File: rtl/motion_pkg.sv
// motion_pkg: shared state encoding, command widths and default timing for the plotter move sequencer
package motion_pkg;
    localparam int DW = 16;
    localparam int AW = DW + 1;
    localparam int EW = DW + 2;
    localparam int STEP_DIV_DEF = 50000;
    localparam int PULSE_W_DEF = 25000;
    localparam int PEN_SETTLE_DEF = 12500000;
    typedef enum logic [1:0] {IDLE, PEN, STEP, DONE} state_t;
    // Two's-complement magnitude widened by one bit so -32768 maps to 32768
    function automatic logic [AW-1:0] mag(input logic [DW-1:0] v);
        return v[DW-1] ? -{1'b1, v} : {1'b0, v};
    endfunction
endpackage

// File: rtl/motion_sequencer_step_timer.sv
// step_timer: free-running step tick divider plus fixed-width pulse shaper shared by both axes
module step_timer #(
    parameter int STEP_DIV = 50000,
    parameter int PULSE_W = 25000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tick,
    output logic pulse_active
);
    localparam int CW = $clog2(STEP_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    logic pulse_q, pulse_d;
    always_comb begin
        tick = en && cnt_q == CW'(STEP_DIV - 1);
        cnt_d = (!en || tick) ? '0 : cnt_q + 1'b1;
        // pulse is high while the counter runs 0..PULSE_W-1 after a tick
        pulse_d = en && (tick || (pulse_q && cnt_q != CW'(PULSE_W - 1)));
        pulse_active = pulse_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pulse_q <= pulse_d;
        end
    end
endmodule

// File: rtl/motion_sequencer.sv
// motion_sequencer: accepts a relative move, settles the pen, then emits Bresenham-interleaved X/Y steps
module motion_sequencer
    import motion_pkg::*;
#(
    parameter int STEP_DIV = STEP_DIV_DEF,
    parameter int PULSE_W = PULSE_W_DEF,
    parameter int PEN_SETTLE = PEN_SETTLE_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_dx,
    input  logic [DW-1:0] cmd_dy,
    input  logic          cmd_pen,
    input  logic          abort,
    output logic          x_step,
    output logic          y_step,
    output logic          x_dir,
    output logic          y_dir,
    output logic          pen_down,
    output logic          busy,
    output logic          done
);
    state_t state_q, state_d;
    logic x_dir_q, x_dir_d, y_dir_q, y_dir_d, pen_q, pen_d, xs_q, xs_d, ys_q, ys_d;
    logic [AW-1:0] adx_q, adx_d, ady_q, ady_d, rem_q, rem_d;
    logic signed [EW-1:0] err_q, err_d, err_sub;
    logic [31:0] settle_q, settle_d;
    logic [AW-1:0] cadx, cady, cmaj, major, minor;
    logic accept, abort_now, pen_chg, zero_q, x_maj, minor_step, tick, pulse_active;

    step_timer #(.STEP_DIV(STEP_DIV), .PULSE_W(PULSE_W)) u_timer (
        .clk(clk),
        .reset_n(reset_n),
        .en(state_q == STEP && !abort),
        .tick(tick),
        .pulse_active(pulse_active)
    );

    always_comb begin
        accept = cmd_valid && state_q == IDLE;
        abort_now = abort && state_q != IDLE;
        cadx = mag(cmd_dx);
        cady = mag(cmd_dy);
        cmaj = cadx >= cady ? cadx : cady;
        pen_chg = cmd_pen != pen_q;
        zero_q = adx_q == '0 && ady_q == '0;
        x_maj = adx_q >= ady_q;
        major = x_maj ? adx_q : ady_q;
        minor = x_maj ? ady_q : adx_q;
        err_sub = err_q - $signed({1'b0, minor});
        minor_step = err_sub[EW-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = pen_chg ? PEN : (cmaj == '0 ? DONE : STEP);
            PEN:  if (settle_q == 32'd1) state_d = zero_q ? DONE : STEP;
            STEP: if (rem_q == '0 && !pulse_active) state_d = DONE;
            DONE: state_d = IDLE;
        endcase
        if (abort_now) state_d = IDLE;
    end

    always_comb begin
        cmd_ready = state_q == IDLE;
        busy = state_q != IDLE;
        done = state_q == DONE;
        x_step = xs_q && pulse_active;
        y_step = ys_q && pulse_active;
        x_dir = x_dir_q;
        y_dir = y_dir_q;
        pen_down = pen_q;
    end

    always_comb begin
        {x_dir_d, y_dir_d, pen_d, adx_d, ady_d} = {x_dir_q, y_dir_q, pen_q, adx_q, ady_q};
        {rem_d, err_d, settle_d, xs_d, ys_d} = {rem_q, err_q, settle_q, xs_q, ys_q};
        if (accept) begin
            x_dir_d = !cmd_dx[DW-1];
            y_dir_d = !cmd_dy[DW-1];
            adx_d = cadx;
            ady_d = cady;
            pen_d = cmd_pen;
            settle_d = pen_chg ? 32'(PEN_SETTLE) : '0;
            err_d = $signed({1'b0, cmaj >> 1});
            rem_d = cmaj;
        end
        if (state_q == PEN) settle_d = settle_q - 32'd1;
        // ticks after the last step only time out the final pulse; they must not fire again
        if (tick) begin
            xs_d = rem_q != '0 && (x_maj || minor_step);
            ys_d = rem_q != '0 && (!x_maj || minor_step);
            if (rem_q != '0) begin
                rem_d = rem_q - 1'b1;
                err_d = minor_step ? err_sub + $signed({1'b0, major}) : err_sub;
            end
        end
        if (abort_now) {rem_d, err_d, settle_d, xs_d, ys_d} = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {x_dir_q, y_dir_q} <= 2'b11;
            {pen_q, xs_q, ys_q} <= '0;
            {adx_q, ady_q, rem_q, err_q, settle_q} <= '0;
        end else begin
            {x_dir_q, y_dir_q, pen_q, xs_q, ys_q} <= {x_dir_d, y_dir_d, pen_d, xs_d, ys_d};
            {adx_q, ady_q, rem_q, err_q, settle_q} <= {adx_d, ady_d, rem_d, err_d, settle_d};
        end
    end
endmodule
